// File: rtl/varredura_display.sv
// Purpose : time-multiplexing scan controller for a 4-digit 7-segment display;
//           cycles seletor 0..3 (unidade, dezena, agroDef, estado) every DIV
//           clocks and drives the matching active-low anode, blanking the first
//           GUARD cycles of each slot to suppress ghosting.
// Latency : all outputs registered; anodos is computed from next-state
//           presc/seletor so it lines up with seletor in the same cycle.
// Stall   : habilita=0 freezes presc/seletor, darkens the display and
//           suppresses tick_quadro; resuming continues the held slot.
//
// Ports   : clk          system clock, rising edge
//           rst_n        asynchronous active-low reset
//           habilita     1 = scan runs, 0 = frozen and dark
//           mascara[3:0] per-digit enable (bit i lets digit i light)
//           brilho[2:0]  duty select, (brilho+1)/8 on (only with VARREDURA_BRILHO_EN)
//           seletor[1:0] digit index to the segment mux
//           anodos[3:0]  digit enables, active-low, at most one bit low
//           tick_quadro  one-cycle pulse when seletor wraps 3 -> 0
//
// Optional: define VARREDURA_BRILHO_EN to add the brilho input and PWM
//           dimming inside the active part of each slot.

module varredura_display #(
    parameter int DIV   = 50000,
    parameter int GUARD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       habilita,
    input  logic [3:0] mascara,
`ifdef VARREDURA_BRILHO_EN
    input  logic [2:0] brilho,
`endif
    output logic [1:0] seletor,
    output logic [3:0] anodos,
    output logic       tick_quadro
);

    localparam int             PW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  LAST    = PW'(DIV - 1);
    localparam logic [PW-1:0]  GUARD_P = PW'(GUARD);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q,   sel_d;
    logic [3:0]    an_q,    an_d;
    logic          tick_q,  tick_d;
    logic          lit;
`ifdef VARREDURA_BRILHO_EN
    logic [PW-1:0] offs;
`endif

    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        an_d    = 4'b1111;
        lit     = 1'b0;
`ifdef VARREDURA_BRILHO_EN
        offs    = '0;
`endif
        if (habilita) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                sel_d   = sel_q + 2'd1;
                tick_d  = (sel_q == 2'd3);
            end else begin
                presc_d = presc_q + PW'(1);
            end

            // Decide from next-state values so the anode is aligned with
            // the seletor value that becomes visible on the same edge.
            lit = (presc_d >= GUARD_P) && mascara[sel_d];
`ifdef VARREDURA_BRILHO_EN
            // Position within the active window, folded into an 8-cycle PWM period.
            offs = presc_d - GUARD_P;
            lit  = lit && (3'(offs) <= brilho);
`endif
            an_d[sel_d] = ~lit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1111;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seletor     = sel_q;
    assign anodos      = an_q;
    assign tick_quadro = tick_q;

endmodule

// File: tb/tb_varredura_display.sv
// Purpose : self-checking bench for varredura_display with DIV=10, GUARD=2;
//           a cycle model pushes the expected seletor/anodos/tick on every
//           rising edge and the checker pops and compares on the falling edge.
// Latency : expectations describe the register values after each edge.
// Stall   : exercises habilita freeze/resume, masking and mid-frame reset.

module tb_varredura_display;

    localparam int DIV   = 10;
    localparam int GUARD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       habilita;
    logic [3:0] mascara;
    logic [1:0] seletor;
    logic [3:0] anodos;
    logic       tick_quadro;
`ifdef VARREDURA_BRILHO_EN
    logic [2:0] brilho;
`endif

    int n_checks = 0;
    int n_errors = 0;

    varredura_display #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .habilita    (habilita),
        .mascara     (mascara),
`ifdef VARREDURA_BRILHO_EN
        .brilho      (brilho),
`endif
        .seletor     (seletor),
        .anodos      (anodos),
        .tick_quadro (tick_quadro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];
    int   m_presc = 0;
    int   m_sel   = 0;

    function automatic bit bright_ok(input int p);
`ifdef VARREDURA_BRILHO_EN
        return ((p - GUARD) % 8) <= int'(brilho);
`else
        return (p >= 0);
`endif
    endfunction

    always @(negedge rst_n) begin
        m_presc = 0;
        m_sel   = 0;
        sb_q.delete();
    end

    always @(posedge clk) begin
        exp_t e;
        e.tick = 1'b0;
        e.an   = 4'b1111;
        if (!rst_n) begin
            m_presc = 0;
            m_sel   = 0;
        end else if (habilita) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                if (m_sel == 3) begin
                    m_sel  = 0;
                    e.tick = 1'b1;
                end else begin
                    m_sel = m_sel + 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
            if (m_presc >= GUARD && mascara[m_sel] && bright_ok(m_presc))
                e.an[m_sel] = 1'b0;
        end
        e.sel = m_sel[1:0];
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("sb_seletor", 32'(seletor), 32'(x.sel));
            chk("sb_anodos", 32'(anodos), 32'(x.an));
            chk("sb_tick", 32'(tick_quadro), 32'(x.tick));
            chk("onehot_low", 32'($countones(~anodos) <= 1), 32'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ticks;
        int cnt;
        rst_n    = 1'b0;
        habilita = 1'b1;
        mascara  = 4'b1111;
`ifdef VARREDURA_BRILHO_EN
        brilho   = 3'd7;
`endif
        step(2);
        chk("rst_seletor", 32'(seletor), 32'd0);
        chk("rst_anodos", 32'(anodos), 32'hF);
        chk("rst_tick", 32'(tick_quadro), 32'd0);
        rst_n = 1'b1;

        // Free run: two frames, one tick per frame, always at seletor 0.
        ticks = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tick_quadro) begin
                ticks++;
                chk("tick_at_sel0", 32'(seletor), 32'd0);
            end
        end
        chk("ticks_per_80", 32'(ticks), 32'd2);

        // Masked frame: only slots 1 and 3 light; frame length unchanged.
        mascara = 4'b1010;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick_quadro) ticks++;
        end
        chk("ticks_masked", 32'(ticks), 32'd1);

        // Clear mask bit 1 in the middle of slot 1.
        mascara = 4'b1111;
        step(15);
        chk("pre_mask_edge_an", 32'(anodos), 32'hD);
        mascara = 4'b1101;
        step(1);
        chk("mask_edge_an", 32'(anodos), 32'hF);
        chk("mask_edge_sel", 32'(seletor), 32'd1);
        step(10);
        mascara = 4'b1111;

        // Asynchronous reset mid-frame, between clock edges.
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(seletor), 32'd0);
        chk("async_rst_an", 32'(anodos), 32'hF);
        chk("async_rst_tick", 32'(tick_quadro), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_guard", 32'(anodos), 32'hF);
        step(1);
        chk("post_rst_lit", 32'(anodos), 32'hE);

        // Freeze at seletor=2, presc=5 for 7 cycles.
        step(23);
        chk("pre_freeze_sel", 32'(seletor), 32'd2);
        habilita = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("freeze_sel", 32'(seletor), 32'd2);
            chk("freeze_an", 32'(anodos), 32'hF);
            chk("freeze_tick", 32'(tick_quadro), 32'd0);
        end
        habilita = 1'b1;
        step(1);
        chk("resume_an", 32'(anodos), 32'hB);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (seletor != 2'd2) break;
            cnt++;
        end
        chk("resume_len", 32'(cnt), 32'd4);
        chk("resume_next_sel", 32'(seletor), 32'd3);

`ifdef VARREDURA_BRILHO_EN
        brilho = 3'd1;
        step(40);
        brilho = 3'd7;
        step(20);
`endif
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/varredura_display.md
Name: varredura_display

Overview:
- Time-multiplexing scan controller for the 4-digit 7-segment display.
- Drives the 2-bit digit selector that picks the segment pattern:
  - 0 = unidade
  - 1 = dezena
  - 2 = agroDef
  - 3 = estado
- Drives the matching active-low digit (anode) enables so each digit lights in its own time slot.
- Inserts a blanking guard at each slot start to suppress ghosting. Sits between the system clock and the segment mux/display pins.

Parameters:
- DIV, 50000: clock cycles per digit slot (1 ms at 50 MHz); must be >= 2.
- GUARD, 8: blanking cycles at the start of each slot; must satisfy 0 <= GUARD < DIV. A value of 0 means no blanking.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- habilita  input  1  1 = scan runs; 0 = scan frozen and display dark.
- mascara  input  4  per-digit enable; bit i = 1 lets digit i light.
- seletor  output  2  digit index to the segment mux.
- anodos  output  4  digit enables, active-low, at most one bit low.
- tick_quadro  output  1  one-cycle pulse on each completed frame (slot 3 -> slot 0).

Behaviour:
- State:
  - prescaler presc, width clog2(DIV), range 0..DIV-1.
  - slot counter driving seletor.
  - All outputs registered; no combinational path from inputs to outputs.
- Reset (rst_n low, asynchronous, immediate):
  - presc = 0, seletor = 0, anodos = 4'b1111, tick_quadro = 0.
  - First clock edge after release is presc 0 -> 1 of slot 0.
- habilita = 1, each cycle:
  - presc increments. At presc = DIV-1 it wraps to 0 and seletor advances by 1 modulo 4 (3 -> 0 wrap).
  - tick_quadro = 1 exactly on the cycle in which seletor becomes 0 by wrap from 3; else 0. Not asserted on leaving reset.
- anodos register, next value computed from next-state presc/seletor so it is aligned with seletor:
  - anodos[seletor] = 0 iff habilita = 1, presc >= GUARD and mascara[seletor] = 1.
  - All other bits are 1.
- Masked digits keep their slot (dark for all DIV cycles); refresh period stays 4*DIV regardless of mascara.
- mascara change: takes effect on the next clock edge, including mid-slot.
- habilita = 0:
  - presc and seletor hold.
  - anodos = 4'b1111 from the next edge.
  - tick_quadro = 0.
- habilita back to 1: resumes counting from the held presc/seletor; the slot completes its remaining cycles. The guard is not re-inserted, so the digit lights immediately if presc >= GUARD.
- Reset mid-frame: all state returns to reset values immediately regardless of slot or presc.
- Never more than one anodos bit low in any cycle, including at slot boundaries.

Optional Feature:
- Macro: VARREDURA_BRILHO_EN.
- Defined:
  - Adds input brilho[2:0].
  - In the active part of a slot (presc >= GUARD), the enabled digit is driven low only when ((presc - GUARD) mod 8) <= brilho, giving a duty of (brilho+1)/8.
  - brilho = 7 gives full on. brilho changes take effect next cycle.
- Not defined: port absent; the active part of the slot is fully on, as specified above.

Test Plan:
- Reset: DIV=10, GUARD=2, run mid-frame, pull rst_n low between clock edges -> seletor=0, anodos=1111, tick_quadro=0 before the next edge; after release, slot 0 starts at presc 0.
- Free run: DIV=10, GUARD=2, habilita=1, mascara=1111 -> each 10-cycle slot shows anodos 1111 for 2 cycles then the slot's one-hot-low pattern (1110/1101/1011/0111) for 8. seletor sequence is 0,1,2,3,0 in 10-cycle steps. tick_quadro is exactly one pulse per 40 cycles, coincident with seletor 3 -> 0.
- Mask: mascara=1010 -> slots 0 and 2 anodos=1111 throughout; slots 1 and 3 show 1101 and 0111 after the guard. Frame still 40 cycles.
- Freeze: habilita=0 at seletor=2, presc=5 for 7 cycles -> anodos=1111, seletor=2 held, no tick. On resume: anodos=1011 at once, slot 2 lasts 4 more cycles, then seletor=3.
- Mask edge: mascara bit 1 cleared mid-slot 1 -> anodos returns to 1111 on the next edge; seletor timing unchanged.
- VARREDURA_BRILHO_EN: brilho=1, DIV=18, GUARD=2 -> in each active 16-cycle window the digit is low for cycles 0-1 and 8-9 only. brilho=7 -> low for all 16.
